ula_serial_74181: RTL and testbench
===================================

// Module: ula_serial_74181
// PURPOSE
//  Multi-cycle 74181-compatible ALU for operands wider than 4 bits: SLICES x 4-bit slices.
//  Processes SLICES_PER_CYCLE slices per clock, carrying between steps in a register.
//  Uses a valid/ready handshake on input and output. Successor to the single 4-bit
//  combinational ALU; produces the same 32 functions plus zero and signed-overflow flags.
// PARAMETERS
//  SLICES            4  number of 4-bit slices; WIDTH = 4*SLICES (default 16)
//  SLICES_PER_CYCLE  1  slices computed per clock; must divide SLICES ($error otherwise)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operation request
//  in_ready   out  1      1 when idle; a transfer occurs when in_valid & in_ready
//  a, b       in   WIDTH  operands, sampled on the accepting edge
//  s          in   4      function select S[3:0]
//  m          in   1      0 = arithmetic, 1 = logic
//  c_in       in   1      carry in, active high (1 = +1)
//  out_valid  out  1      result available
//  out_ready  in   1      consumer accepts the result
//  f          out  WIDTH  result
//  c_out      out  1      carry out of the MSB (arithmetic only, else 0)
//  a_eq_b     out  1      &f (all ones); equals A==B for m=0, s=0110, c_in=0
//  zero       out  1      f == 0
//  ovf        out  1      signed overflow: carry into MSB ^ carry out (arithmetic only, else 0)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Function, applied per bit over the full width:
//   X = A | (B&s[0]) | (~B&s[1]);  Y = (A&B&s[3]) | (A&~B&s[2])
//   m=1: F = ~(X ^ Y).  m=0: {c_out,F} = X + Y + c_in (carry ripples across slices/steps).
//  FSM: IDLE -> RUN on accept; RUN -> DONE after N = SLICES/SLICES_PER_CYCLE steps;
//   DONE -> IDLE when out_ready. in_ready = (state==IDLE). out_valid = (state==DONE).
//  Accept edge: latch a,b,s,m; carry_reg <= c_in (m=1: 0); step <= 0.
//  RUN step k: slices [k*SPC .. k*SPC+SPC-1] computed from carry_reg and written to f;
//   carry_reg <= group carry out. On the last step, also register c_out, ovf, zero, a_eq_b.
//  Latency: accepted on edge T -> out_valid high after edge T+N (N=4 by default).
//  f and the flags may change while out_valid=0. They stay stable while out_valid=1.
//  Backpressure: DONE holds with all outputs stable while out_ready=0.
//   in_valid is ignored outside IDLE (no queueing).
//  DONE & out_ready: return to IDLE. New input is accepted no earlier than the next edge
//   (throughput 1 op per N+2 cycles).
//  Width rules: carry is 1 bit between groups. Overflow uses the carry into bit WIDTH-1.
//   Arithmetic wraps modulo 2^WIDTH.
//  Reset (any time, including mid-RUN): state=IDLE, f=0, c_out=0, a_eq_b=0, zero=0, ovf=0,
//   out_valid=0, busy=0, carry_reg=0, step=0. An in-flight operation is discarded.
//   in_ready=1 during and after reset.
//  SLICES=1 or SLICES_PER_CYCLE=SLICES: N=1; the RUN state lasts exactly one cycle.
// STRUCTURE
//  ula_pkg: localparam SLICE_W=4; typedef enum {IDLE,RUN,DONE} ula_state_t; opcode
//   localparams (e.g. OP_ADD=4'b1001, OP_SUB_M1=4'b0110, OP_A=4'b1111 logic).
//  ula_slice_4b (combinational): a,b[3:0], s, m, c_in -> f[3:0], c_out, c_msb (carry into bit 3).
//   Chained SLICES_PER_CYCLE times per step via generate; the top level holds FSM, counter
//   and registers.
// TESTING (SLICES=4, SPC=1 unless noted; check at out_valid)
//  1 m=0 s=1001 A=1234h B=0FFFh c_in=0 -> f=2233h c_out=0 ovf=0; out_valid 4 edges after accept.
//  2 m=0 s=1001 A=FFFFh B=0001h c_in=0 -> f=0000h c_out=1 zero=1 ovf=0 (carry through all slices).
//  3 m=0 s=0110 c_in=0: A=B=5A5Ah -> f=FFFFh a_eq_b=1 c_out=0.
//    A=5A5Bh B=5A5Ah -> f=0000h a_eq_b=0 c_out=1.
//  4 m=0 s=1001 A=7FFFh B=0001h c_in=0 -> f=8000h ovf=1 c_out=0.
//    Repeat with SLICES_PER_CYCLE=2 and 4: same results, latency 2 and 1.
//  5 m=1, all 16 s, A=A5C3h B=0FF0h c_in=1 -> f matches ~(X^Y) model (s=0110 -> AA33h,
//    s=0011 -> 0000h, s=1100 -> FFFFh); c_out=0 ovf=0.
//  6 out_ready=0 for 5 cycles with in_valid=1 and new operands -> f and flags stable, in_ready=0,
//    second op not taken. rst_n=0 mid-RUN -> all outputs 0, in_ready=1; next op is correct.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared types and constants for the sliced 74181-compatible ALU
package ula_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ula_state_t;

    // A few well-known select codes (arithmetic ones assume m=0, logic ones m=1)
    localparam logic [3:0] OP_ADD    = 4'b1001;
    localparam logic [3:0] OP_SUB_M1 = 4'b0110;
    localparam logic [3:0] OP_A      = 4'b1111;
    localparam logic [3:0] OP_XNOR   = 4'b1001;
    localparam logic [3:0] OP_ZERO   = 4'b0011;
    localparam logic [3:0] OP_ONES   = 4'b1100;

endpackage

// File: rtl/ula_slice_4b.sv
// rtl/ula_slice_4b.sv - one combinational 4-bit 74181-style slice
module ula_slice_4b
    import ula_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [3:0]         s,
    input  logic               m,
    input  logic               c_in,
    output logic [SLICE_W-1:0] f,
    output logic               c_out,
    output logic               c_msb
);

    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W:0]   sum;
    logic [SLICE_W-1:0] low;

    assign x = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
    assign y = (a & b & {SLICE_W{s[3]}}) | (a & ~b & {SLICE_W{s[2]}});

    assign sum = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, c_in};
    // Sum of the three low bits only; its top bit is the carry into bit 3
    assign low = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, c_in};

    always_comb begin
        f     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
        c_msb = low[SLICE_W-1];
        if (m) begin
            f     = ~(x ^ y);
            c_out = 1'b0;
            c_msb = 1'b0;
        end
    end

endmodule

// File: rtl/ula_serial_74181.sv
// rtl/ula_serial_74181.sv - multi-cycle 74181-compatible ALU, SLICES_PER_CYCLE slices per step
module ula_serial_74181
    import ula_pkg::*;
#(
    parameter int SLICES           = 4,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*SLICES-1:0] a,
    input  logic [SLICE_W*SLICES-1:0] b,
    input  logic [3:0]                s,
    input  logic                      m,
    input  logic                      c_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*SLICES-1:0] f,
    output logic                      c_out,
    output logic                      a_eq_b,
    output logic                      zero,
    output logic                      ovf,
    output logic                      busy
);

    localparam int WIDTH  = SLICE_W * SLICES;
    localparam int SPC    = SLICES_PER_CYCLE;
    localparam int GW     = SLICE_W * SPC;
    localparam int N      = SLICES / SPC;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;

    if (SLICES % SLICES_PER_CYCLE != 0) begin : g_bad_cfg
        $error("SLICES_PER_CYCLE must divide SLICES");
    end

    ula_state_t         state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         s_q, s_d;
    logic               m_q, m_d;
    logic [WIDTH-1:0]   f_q, f_d;
    logic               c_out_q, c_out_d;
    logic               a_eq_b_q, a_eq_b_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [GW-1:0]      grp_a, grp_b, grp_f;
    logic [SPC:0]       chain;
    logic [SPC-1:0]     cmsb;
    logic               c_into_msb;
    logic [WIDTH-1:0]   f_run;
    logic               last_step;

    assign grp_a = a_q[step_q*GW +: GW];
    assign grp_b = b_q[step_q*GW +: GW];
    assign chain[0] = carry_q;

    for (genvar g = 0; g < SPC; g++) begin : g_slice
        ula_slice_4b u_slice (
            .a     (grp_a[g*SLICE_W +: SLICE_W]),
            .b     (grp_b[g*SLICE_W +: SLICE_W]),
            .s     (s_q),
            .m     (m_q),
            .c_in  (chain[g]),
            .f     (grp_f[g*SLICE_W +: SLICE_W]),
            .c_out (chain[g+1]),
            .c_msb (cmsb[g])
        );
    end

    // Only the top slice of the group can hold the operand MSB on the last step
    assign c_into_msb = 1'(cmsb >> (SPC - 1));
    assign last_step  = (step_q == STEP_W'(N - 1));

    always_comb begin
        f_run = f_q;
        f_run[step_q*GW +: GW] = grp_f;
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        f_d      = f_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    m_d     = m;
                    carry_d = m ? 1'b0 : c_in;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                f_d     = f_run;
                carry_d = m_q ? 1'b0 : chain[SPC];
                if (last_step) begin
                    c_out_d  = m_q ? 1'b0 : chain[SPC];
                    ovf_d    = m_q ? 1'b0 : (c_into_msb ^ chain[SPC]);
                    zero_d   = (f_run == '0);
                    a_eq_b_d = &f_run;
                    step_d   = '0;
                    state_d  = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign f         = f_q;
    assign c_out     = c_out_q;
    assign a_eq_b    = a_eq_b_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ula_serial_74181.sv
// tb/tb_ula_serial_74181.sv - self-checking bench for ula_serial_74181 at 1, 2 and 4 slices per step
module tb_ula_serial_74181;
    import ula_pkg::*;

    typedef struct {
        logic [15:0] f;
        logic        c_out;
        logic        ovf;
        logic        zero;
        logic        aeqb;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cin;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, c_in, out_ready;
    logic        in_valid  [3];
    logic        in_ready_w[3], out_valid_w[3], c_out_w[3], a_eq_b_w[3];
    logic        zero_w[3], ovf_w[3], busy_w[3];
    logic [15:0] f_w[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        ula_serial_74181 #(.SLICES(4), .SLICES_PER_CYCLE(1 << gi)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready_w[gi]),
            .a         (a),
            .b         (b),
            .s         (s),
            .m         (m),
            .c_in      (c_in),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .f         (f_w[gi]),
            .c_out     (c_out_w[gi]),
            .a_eq_b    (a_eq_b_w[gi]),
            .zero      (zero_w[gi]),
            .ovf       (ovf_w[gi]),
            .busy      (busy_w[gi])
        );
    end

    // Full-width reference: X/Y per bit, then plain integer addition
    function automatic res_t model(input logic [15:0] av, bv, input logic [3:0] sv,
                                   input logic mv, cv);
        res_t r;
        logic [15:0] x, y;
        int sum, low;
        x = av | (bv & {16{sv[0]}}) | (~bv & {16{sv[1]}});
        y = (av & bv & {16{sv[3]}}) | (av & ~bv & {16{sv[2]}});
        if (mv) begin
            r.f     = ~(x ^ y);
            r.c_out = 1'b0;
            r.ovf   = 1'b0;
        end else begin
            sum     = int'(x) + int'(y) + int'(cv);
            low     = int'(x & 16'h7fff) + int'(y & 16'h7fff) + int'(cv);
            r.f     = sum[15:0];
            r.c_out = sum[16];
            r.ovf   = low[15] ^ sum[16];
        end
        r.zero = (r.f == 16'h0);
        r.aeqb = &r.f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cmp_res(input string name, input res_t got, input res_t exp);
        chk({name, ".f"},     32'(got.f),     32'(exp.f));
        chk({name, ".c_out"}, 32'(got.c_out), 32'(exp.c_out));
        chk({name, ".ovf"},   32'(got.ovf),   32'(exp.ovf));
        chk({name, ".zero"},  32'(got.zero),  32'(exp.zero));
        chk({name, ".a_eq_b"},32'(got.aeqb),  32'(exp.aeqb));
    endtask

    task automatic sample(input int idx, output res_t r);
        r.f     = f_w[idx];
        r.c_out = c_out_w[idx];
        r.ovf   = ovf_w[idx];
        r.zero  = zero_w[idx];
        r.aeqb  = a_eq_b_w[idx];
    endtask

    task automatic start_op(input int idx, input logic [15:0] av, bv, input logic [3:0] sv,
                            input logic mv, cv);
        @(negedge clk);
        a = av; b = bv; s = sv; m = mv; c_in = cv;
        in_valid[idx] = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready_w[idx]), 32'd1);
        @(posedge clk);
        #1 in_valid[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (!out_valid_w[idx] && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid_w[idx]) chk("out_valid_timeout", 32'(out_valid_w[idx]), 32'd1);
    endtask

    task automatic drain(input int idx);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after_drain", 32'(in_ready_w[idx]), 32'd1);
        chk("out_valid_after_drain", 32'(out_valid_w[idx]), 32'd0);
    endtask

    task automatic do_op(input int idx, input logic [15:0] av, bv, input logic [3:0] sv,
                         input logic mv, cv, output res_t r, output int lat);
        start_op(idx, av, bv, sv, mv, cv);
        wait_valid(idx, lat);
        sample(idx, r);
        drain(idx);
    endtask

    vec_t vecs[8];

    initial begin
        res_t r, e, held;
        int   lat;

        vecs[0] = '{16'h1234, 16'h0fff, OP_ADD,    1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'hffff, 16'h0001, OP_ADD,    1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[2] = '{16'h5a5a, 16'h5a5a, OP_SUB_M1, 1'b0, 1'b0, '{16'hffff, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[3] = '{16'h5a5b, 16'h5a5a, OP_SUB_M1, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{16'h7fff, 16'h0001, OP_ADD,    1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{16'ha5c3, 16'h0ff0, 4'b0110,   1'b1, 1'b1, '{16'haa33, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6] = '{16'ha5c3, 16'h0ff0, OP_ZERO,   1'b1, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[7] = '{16'ha5c3, 16'h0ff0, OP_ONES,   1'b1, 1'b1, '{16'hffff, 1'b0, 1'b0, 1'b0, 1'b1}};

        rst_n = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            sample(i, r);
            cmp_res("reset", r, '{16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
            chk("reset.in_ready",  32'(in_ready_w[i]),  32'd1);
            chk("reset.out_valid", 32'(out_valid_w[i]), 32'd0);
            chk("reset.busy",      32'(busy_w[i]),      32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on every slicing; latency shrinks with more slices per step
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 8; v++) begin
                do_op(d, vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].m, vecs[v].cin, r, lat);
                cmp_res($sformatf("vec%0d_spc%0d", v, 1 << d), r, vecs[v].exp);
                chk($sformatf("latency_spc%0d", 1 << d), 32'(lat), 32'(4 >> d));
            end
        end

        for (int sv = 0; sv < 16; sv++) begin
            do_op(0, 16'ha5c3, 16'h0ff0, 4'(sv), 1'b1, 1'b1, r, lat);
            cmp_res($sformatf("logic_s%0d", sv), r, model(16'ha5c3, 16'h0ff0, 4'(sv), 1'b1, 1'b1));
        end

        for (int t = 0; t < 40; t++) begin
            logic [15:0] ra, rb;
            logic [3:0]  rs;
            logic        rm, rc;
            int          idx;
            ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
            rm = 1'($urandom);  rc = 1'($urandom);  idx = int'($urandom_range(0, 2));
            do_op(idx, ra, rb, rs, rm, rc, r, lat);
            cmp_res($sformatf("rand%0d", t), r, model(ra, rb, rs, rm, rc));
        end

        // Backpressure: held result, new requests ignored
        start_op(0, 16'h7fff, 16'h0001, OP_ADD, 1'b0, 1'b0);
        wait_valid(0, lat);
        sample(0, held);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'b0; c_in = 1'b1;
            in_valid[0] = 1'b1;
            @(posedge clk);
            #1;
            sample(0, r);
            cmp_res("backpressure_hold", r, held);
            chk("backpressure.f", 32'(f_w[0]), 32'h8000);
            chk("backpressure.out_valid", 32'(out_valid_w[0]), 32'd1);
            chk("backpressure.in_ready", 32'(in_ready_w[0]), 32'd0);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        drain(0);
        chk("backpressure.not_taken", 32'(busy_w[0]), 32'd0);

        // Reset in the middle of RUN discards the operation
        start_op(0, 16'h1234, 16'h0fff, OP_ADD, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("midrun.busy", 32'(busy_w[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(0, r);
        cmp_res("midrun_reset", r, '{16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("midrun.in_ready",  32'(in_ready_w[0]),  32'd1);
        chk("midrun.out_valid", 32'(out_valid_w[0]), 32'd0);
        chk("midrun.busy_low",  32'(busy_w[0]),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 16'h1234, 16'h0fff, OP_ADD, 1'b0, 1'b0, r, lat);
        e = model(16'h1234, 16'h0fff, OP_ADD, 1'b0, 1'b0);
        cmp_res("after_reset", r, e);
        chk("after_reset.latency", 32'(lat), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
